// File: rtl/pc_unit.sv
// pc_unit: program-counter register with sequential increment, absolute jump,
// PC-relative branch and an optional circular return-address stack.
// Optional feature macro: PC_RAS_EN (defined = return-address stack present;
// undefined = call_en/ret_en ignored, ras_empty=1, ras_full=0, ras_err=0).
module pc_unit #(
    parameter int AW        = 11,
    parameter int INC       = 1,
    parameter int OW        = 8,
    parameter int RESET_VEC = 0,
    parameter int RAS_D     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          jump_en,
    input  logic [AW-1:0] jump_addr,
    input  logic          branch_en,
    input  logic [OW-1:0] branch_off,
    input  logic          call_en,
    input  logic          ret_en,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] npc,
    output logic          wrap,
    output logic          ras_empty,
    output logic          ras_full,
    output logic          ras_err
);

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_CALL,
        SEL_RET
    } sel_e;

    sel_e          sel;
    logic [AW:0]   seq_sum;     // one extra bit catches the wrap carry
    logic [AW-1:0] branch_tgt;
    logic [AW-1:0] pc_next;

    assign seq_sum    = {1'b0, pc} + (AW+1)'(INC);
    assign npc        = seq_sum[AW-1:0];
    assign branch_tgt = pc + AW'($signed(branch_off));

`ifdef PC_RAS_EN
    localparam int            PW   = $clog2(RAS_D);
    localparam logic [PW:0]   FULL = (PW+1)'(RAS_D);

    logic [AW-1:0] stack [RAS_D];
    logic [PW-1:0] sp;          // next free slot; wraps modulo RAS_D
    logic [PW:0]   count;
    logic [AW-1:0] ras_top;
    logic          ret_fail;
    logic          err_q;

    assign ras_top   = stack[sp - 1'b1];
    assign ras_empty = (count == '0);
    assign ras_full  = (count == FULL);
    assign ras_err   = err_q;

    // Priority select: ret > call > jump > branch > sequential; empty ret falls to sequential.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        sel      = SEL_SEQ;
        ret_fail = 1'b0;
        if (ret_en) begin
            if (count != '0) sel = SEL_RET;
            else             ret_fail = 1'b1;
        end else if (call_en) begin
            sel = SEL_CALL;
        end else if (jump_en) begin
            sel = SEL_JUMP;
        end else if (branch_en) begin
            sel = SEL_BRANCH;
        end
    end

    // Stack storage: write the return address on call; oldest slot is overwritten when full.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are deliberately not reset; the count decides which entries are valid.
        if (!stall && sel == SEL_CALL) stack[sp] <= npc;
    end

    // Stack pointer, occupancy count and the empty-return error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp    <= '0;
            count <= '0;
            err_q <= 1'b0;
        end else if (stall) begin
            err_q <= 1'b0;
        end else begin
            err_q <= ret_fail;
            if (sel == SEL_CALL) begin
                sp <= sp + 1'b1;
                if (count != FULL) count <= count + 1'b1;
            end else if (sel == SEL_RET) begin
                sp    <= sp - 1'b1;
                count <= count - 1'b1;
            end
        end
    end
`else
    logic unused_ras;

    assign unused_ras = &{1'b0, call_en, ret_en, 32'(RAS_D)};
    assign ras_empty  = 1'b1;
    assign ras_full   = 1'b0;
    assign ras_err    = 1'b0;

    // Priority select without a stack: jump > branch > sequential.
    always_comb begin
        sel = SEL_SEQ;
        if (jump_en)        sel = SEL_JUMP;
        else if (branch_en) sel = SEL_BRANCH;
    end
`endif

    // Next-PC multiplexer driven by the selected source.
    always_comb begin
        pc_next = npc;
        case (sel)
            SEL_BRANCH: pc_next = branch_tgt;
            SEL_JUMP:   pc_next = jump_addr;
            SEL_CALL:   pc_next = jump_addr;
`ifdef PC_RAS_EN
            SEL_RET:    pc_next = ras_top;
`endif
            default:    pc_next = npc;
        endcase
    end

    // PC register and sequential-wrap pulse; stall holds pc and clears the pulse.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            pc   <= AW'(RESET_VEC);
            wrap <= 1'b0;
        end else if (stall) begin
            wrap <= 1'b0;
        end else begin
            pc   <= pc_next;
            wrap <= (sel == SEL_SEQ) && seq_sum[AW];
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed, table-driven checks of pc_unit with default parameters
// (AW=11, INC=1, OW=8, RESET_VEC=0, RAS_D=4); stack sequences depend on PC_RAS_EN.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, jump_en, branch_en, call_en, ret_en;
    logic [10:0] jump_addr;
    logic [7:0]  branch_off;
    logic [10:0] pc, npc;
    logic        wrap, ras_empty, ras_full, ras_err;

    int passed = 0;
    int total  = 0;

    pc_unit dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .branch_en  (branch_en),
        .branch_off (branch_off),
        .call_en    (call_en),
        .ret_en     (ret_en),
        .pc         (pc),
        .npc        (npc),
        .wrap       (wrap),
        .ras_empty  (ras_empty),
        .ras_full   (ras_full),
        .ras_err    (ras_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        je;
        logic [10:0] ja;
        logic        be;
        logic [7:0]  bo;
        logic [10:0] exp_pc;
        logic        exp_wrap;
    } vec_t;

    vec_t vecs [22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else             passed++;
    endtask

    // Drive one cycle of requests, then sample 1 time unit after the rising edge.
    task automatic step(input logic st, input logic je, input logic [10:0] ja,
                        input logic be, input logic [7:0] bo, input logic ce, input logic re);
        stall = st; jump_en = je; jump_addr = ja; branch_en = be; branch_off = bo;
        call_en = ce; ret_en = re;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic st, input logic je, input logic [10:0] ja,
                                input logic be, input logic [7:0] bo,
                                input logic [10:0] ep, input logic ew);
        vec_t v;
        v.st = st; v.je = je; v.ja = ja; v.be = be; v.bo = bo; v.exp_pc = ep; v.exp_wrap = ew;
        return v;
    endfunction

    initial begin
        logic [10:0] a;

        vecs[0]  = mk(0, 1, 11'h7FE, 0, 8'h00, 11'h7FE, 0);
        vecs[1]  = mk(0, 0, 11'h000, 0, 8'h00, 11'h7FF, 0);
        vecs[2]  = mk(0, 0, 11'h000, 0, 8'h00, 11'h000, 1);
        vecs[3]  = mk(0, 0, 11'h000, 0, 8'h00, 11'h001, 0);
        vecs[4]  = mk(0, 0, 11'h000, 1, 8'hFD, 11'h7FE, 0);
        vecs[5]  = mk(0, 1, 11'h010, 0, 8'h00, 11'h010, 0);
        vecs[6]  = mk(1, 1, 11'h300, 0, 8'h00, 11'h010, 0);
        vecs[7]  = mk(1, 1, 11'h300, 0, 8'h00, 11'h010, 0);
        vecs[8]  = mk(1, 1, 11'h300, 0, 8'h00, 11'h010, 0);
        vecs[9]  = mk(0, 0, 11'h000, 0, 8'h00, 11'h011, 0);
        vecs[10] = mk(0, 1, 11'h005, 0, 8'h00, 11'h005, 0);
        vecs[11] = mk(0, 1, 11'h200, 1, 8'hFD, 11'h200, 0);
        vecs[12] = mk(0, 1, 11'h005, 0, 8'h00, 11'h005, 0);
        vecs[13] = mk(0, 0, 11'h000, 1, 8'hFD, 11'h002, 0);
        vecs[14] = mk(0, 0, 11'h000, 1, 8'h7F, 11'h081, 0);
        vecs[15] = mk(0, 0, 11'h000, 1, 8'h80, 11'h001, 0);
        vecs[16] = mk(0, 1, 11'h7FF, 0, 8'h00, 11'h7FF, 0);
        vecs[17] = mk(1, 0, 11'h000, 0, 8'h00, 11'h7FF, 0);
        vecs[18] = mk(0, 0, 11'h000, 1, 8'h01, 11'h000, 0);
        vecs[19] = mk(0, 1, 11'h7FF, 0, 8'h00, 11'h7FF, 0);
        vecs[20] = mk(0, 0, 11'h000, 0, 8'h00, 11'h000, 1);
        vecs[21] = mk(0, 1, 11'h155, 0, 8'h00, 11'h155, 0);

        rst = 1'b1;
        stall = 0; jump_en = 0; jump_addr = '0; branch_en = 0; branch_off = '0;
        call_en = 0; ret_en = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset pc", 32'(pc), 32'h000);
        check("reset wrap", 32'(wrap), 0);
        check("reset ras_empty", 32'(ras_empty), 1);
        check("reset ras_full", 32'(ras_full), 0);
        check("reset ras_err", 32'(ras_err), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            step(vecs[i].st, vecs[i].je, vecs[i].ja, vecs[i].be, vecs[i].bo, 0, 0);
            check($sformatf("vec%0d pc", i), 32'(pc), 32'(vecs[i].exp_pc));
            check($sformatf("vec%0d wrap", i), 32'(wrap), 32'(vecs[i].exp_wrap));
            check($sformatf("vec%0d npc", i), 32'(npc), 32'((vecs[i].exp_pc + 11'd1) & 11'h7FF));
        end

        // Asynchronous reset mid-cycle with pc=0x155.
        #2 rst = 1'b1;
        #1;
        check("async reset pc", 32'(pc), 32'h000);
        check("async reset wrap", 32'(wrap), 0);
        check("async reset ras_empty", 32'(ras_empty), 1);
        stall = 0; jump_en = 1; jump_addr = 11'h2AA;
        @(posedge clk);
        #1;
        check("reset holds over edge", 32'(pc), 32'h000);
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 11'h000, 0, 8'h00, 0, 0);
        check("first edge after reset", 32'(pc), 32'h001);

`ifdef PC_RAS_EN
        // Call/return round trip, then return on an empty stack.
        step(0, 1, 11'h020, 0, 8'h00, 0, 0);
        step(0, 0, 11'h100, 0, 8'h00, 1, 0);
        check("call pc", 32'(pc), 32'h100);
        check("call ras_empty", 32'(ras_empty), 0);
        step(0, 0, 11'h000, 0, 8'h00, 0, 1);
        check("ret pc", 32'(pc), 32'h021);
        check("ret ras_empty", 32'(ras_empty), 1);
        check("ret ras_err", 32'(ras_err), 0);
        step(0, 1, 11'h030, 0, 8'h00, 0, 0);
        step(0, 0, 11'h000, 0, 8'h00, 0, 1);
        check("empty ret pc", 32'(pc), 32'h031);
        check("empty ret ras_err", 32'(ras_err), 1);
        step(0, 0, 11'h000, 0, 8'h00, 0, 0);
        check("ras_err pulse ends", 32'(ras_err), 0);

        // call+ret same cycle: ret wins, no push.
        step(0, 1, 11'h050, 0, 8'h00, 0, 0);
        step(0, 0, 11'h100, 0, 8'h00, 1, 0);
        step(0, 0, 11'h300, 0, 8'h00, 1, 1);
        check("call+ret pc", 32'(pc), 32'h051);
        check("call+ret ras_empty", 32'(ras_empty), 1);

        // call with jump_en: same target, push still happens.
        step(0, 1, 11'h060, 0, 8'h00, 0, 0);
        step(0, 1, 11'h200, 0, 8'h00, 1, 0);
        check("call+jump pc", 32'(pc), 32'h200);
        step(0, 0, 11'h000, 0, 8'h00, 0, 1);
        check("call+jump ret pc", 32'(pc), 32'h061);

        // Overflow: five nested calls from A_k = 0x40*k into a depth-4 stack.
        for (int k = 1; k <= 5; k++) begin
            a = 11'(k * 'h40);
            step(0, 1, a, 0, 8'h00, 0, 0);
            step(0, 0, 11'h600, 0, 8'h00, 1, 0);
        end
        check("overflow ras_full", 32'(ras_full), 1);
        for (int k = 5; k >= 2; k--) begin
            step(0, 0, 11'h000, 0, 8'h00, 0, 1);
            check($sformatf("overflow ret%0d pc", k), 32'(pc), 32'(k * 'h40 + 1));
        end
        check("overflow drained ras_empty", 32'(ras_empty), 1);
        step(0, 0, 11'h000, 0, 8'h00, 0, 1);
        check("overflow 5th ret pc", 32'(pc), 32'h082);
        check("overflow 5th ret ras_err", 32'(ras_err), 1);
`else
        // Without the stack, call/ret are ignored and stack flags are constant.
        step(0, 1, 11'h100, 0, 8'h00, 0, 0);
        step(0, 0, 11'h300, 0, 8'h00, 1, 0);
        check("no-ras call ignored", 32'(pc), 32'h101);
        check("no-ras ras_empty", 32'(ras_empty), 1);
        step(0, 0, 11'h000, 0, 8'h00, 0, 1);
        check("no-ras ret ignored", 32'(pc), 32'h102);
        check("no-ras ras_err", 32'(ras_err), 0);
        check("no-ras ras_full", 32'(ras_full), 0);
        step(0, 1, 11'h300, 0, 8'h00, 1, 0);
        check("no-ras call+jump", 32'(pc), 32'h300);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
